ptp_buf: RTL and testbench

Buffered, parametrised successor to the paper tape punch interface on the PDP‑6 IO bus. It decodes its own device code and queues DATAO characters in a DEPTH‑deep FIFO. A motor/speed sequencer then hands the characters one at a time to the Avalon front end, which drives the punch solenoids. Status, PI request and console indicators sit on the same IO bus and panel nets as the single‑buffer punch.

---
 rtl/ptp_pkg.sv | 27 ++
 rtl/ptp_buf_fifo.sv | 57 +++++
 rtl/ptp_buf.sv | 222 ++++++++++++++++++++++
 tb/tb_ptp_buf.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_pkg.sv
// Shared definitions for the buffered paper tape punch: status word layout,
// motor sequencer states and the default IO bus device code.
package ptp_pkg;

  localparam logic [6:0] DEVCODE_DEF = 7'b001_000_0;

  localparam int ST_OVR    = 27;
  localparam int ST_FULL   = 28;
  localparam int ST_EMPTY  = 29;
  localparam int ST_B      = 30;
  localparam int ST_BUSY   = 31;
  localparam int ST_FLAG   = 32;
  localparam int ST_PIA_HI = 33;
  localparam int ST_PIA_LO = 35;

  typedef enum logic [1:0] {
    MOT_OFF,
    MOT_SPINUP,
    MOT_RUN,
    MOT_HOLD
  } mot_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ptp_buf_fifo.sv
// Character FIFO between the IO bus DATAO path and the punch front end.
// A flush empties it in one cycle; storage itself is never reset.
module chr_fifo #(
  parameter int DEPTH  = 4,
  parameter int CHAR_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [CHAR_W-1:0]        din,
  output logic [CHAR_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ptp_buf.sv
// Buffered paper tape punch: IO bus decode, CONO/DATAO registers, character
// FIFO, motor sequencer and the Avalon-style request/read handshake.
module ptp_buf
  import ptp_pkg::*;
#(
  parameter logic [6:0] DEVCODE     = DEVCODE_DEF,
  parameter int         DEPTH       = 4,
  parameter int         CHAR_W      = 8,
  parameter int         SPEED_DLY   = 5000,
  parameter int         CHAR_PERIOD = 800,
  parameter int         IDLE_HOLD   = 20000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iobus_iob_poweron,
  input  logic              iobus_iob_reset,
  input  logic              iobus_datao_clear,
  input  logic              iobus_datao_set,
  input  logic              iobus_cono_clear,
  input  logic              iobus_cono_set,
  input  logic              iobus_iob_fm_datai,
  input  logic              iobus_iob_fm_status,
  input  logic [3:9]        iobus_ios,
  input  logic [0:35]       iobus_iob_in,
  output logic [1:7]        iobus_pi_req,
  output logic [0:35]       iobus_iob_out,
  input  logic              key_tape_feed,
  output logic [CHAR_W-1:0] ptp_ind,
  output logic [8:0]        status_ind,
  input  logic              s_read,
  output logic [31:0]       s_readdata,
  output logic              fe_data_rq
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int MOT_W = $clog2(max2(SPEED_DLY, IDLE_HOLD) + 1);
  localparam int DIV_W = $clog2(CHAR_PERIOD + 1);

  logic              sel;
  logic [4:0]        lvl_p0;
  logic [4:0]        lvl_p1;
  logic [4:0]        ev_p0;
  logic              ev_dclr, ev_dset, ev_cclr, ev_cset, ev_iorst;
  logic              clr;

  logic [2:0]        pia;
  logic              flag, busy, b, ovr;

  logic [CHAR_W-1:0] chr_in;
  logic [CHAR_W-1:0] fifo_din;
  logic [CHAR_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              push, pop, accept;

  mot_state_t        mot_state;
  logic [MOT_W-1:0]  mot_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick, speed, demand;
  logic              unused_ok;

  assign sel = (iobus_ios == DEVCODE);

  // Stage p0: qualified bus levels; p1: their registered copies for edge detection
  always_comb begin
    lvl_p0 = {sel & iobus_datao_clear, sel & iobus_datao_set,
              sel & iobus_cono_clear,  sel & iobus_cono_set,
              iobus_iob_reset | ~iobus_iob_poweron};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lvl_p1 <= '0;
    else       lvl_p1 <= lvl_p0;
  end

  assign ev_p0 = lvl_p0 & ~lvl_p1;
  assign {ev_dclr, ev_dset, ev_cclr, ev_cset, ev_iorst} = ev_p0;
  assign clr = ev_cclr | ev_iorst;

  assign chr_in   = iobus_iob_in[36-CHAR_W:35];
  assign fifo_din = b ? {2'b10, chr_in[CHAR_W-3:0]} : chr_in;
  assign accept   = s_read & fe_data_rq & ~clr;
  assign pop      = accept & ~fifo_empty;
  assign push     = ev_dset & ~fifo_full;

  chr_fifo #(
    .DEPTH  (DEPTH),
    .CHAR_W (CHAR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clr),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Later assignments win: a CONO/DATAO set overrides the idle busy clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pia        <= '0;
      flag       <= 1'b0;
      busy       <= 1'b0;
      b          <= 1'b0;
      ovr        <= 1'b0;
      fe_data_rq <= 1'b0;
    end else if (clr) begin
      pia        <= '0;
      flag       <= 1'b0;
      busy       <= 1'b0;
      b          <= 1'b0;
      ovr        <= 1'b0;
      fe_data_rq <= 1'b0;
    end else begin
      if (fifo_empty && !fe_data_rq) busy <= 1'b0;
      if (accept) begin
        fe_data_rq <= 1'b0;
        flag       <= 1'b1;
      end else if (tick && (!fifo_empty || key_tape_feed)) begin
        fe_data_rq <= 1'b1;
      end
      if (ev_dclr) flag <= 1'b0;
      if (ev_dset) begin
        busy <= 1'b1;
        if (fifo_full) ovr <= 1'b1;
      end
      if (ev_cset) begin
        pia <= iobus_iob_in[33:35];
        if (iobus_iob_in[32]) flag <= 1'b1;
        if (iobus_iob_in[31]) busy <= 1'b1;
        if (iobus_iob_in[30]) b    <= 1'b1;
        if (iobus_iob_in[29]) ovr  <= 1'b0;
      end
    end
  end

  assign demand = busy | key_tape_feed;
  assign speed  = (mot_state == MOT_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mot_state <= MOT_OFF;
      mot_cnt   <= '0;
    end else begin
      case (mot_state)
        MOT_OFF: begin
          mot_cnt <= '0;
          if (demand) mot_state <= MOT_SPINUP;
        end
        MOT_SPINUP: begin
          if (mot_cnt == MOT_W'(SPEED_DLY - 1)) begin
            mot_state <= MOT_RUN;
            mot_cnt   <= '0;
          end else begin
            mot_cnt <= mot_cnt + MOT_W'(1);
          end
        end
        MOT_RUN: begin
          mot_cnt <= '0;
          if (!demand) mot_state <= MOT_HOLD;
        end
        MOT_HOLD: begin
          if (demand) begin
            mot_state <= MOT_RUN;
            mot_cnt   <= '0;
          end else if (mot_cnt == MOT_W'(IDLE_HOLD - 1)) begin
            mot_state <= MOT_OFF;
            mot_cnt   <= '0;
          end else begin
            mot_cnt <= mot_cnt + MOT_W'(1);
          end
        end
        default: begin
          mot_state <= MOT_OFF;
          mot_cnt   <= '0;
        end
      endcase
    end
  end

  // The punch divider only runs at speed, so the first request lands a full period into RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  div_cnt <= '0;
    else if (!speed)                            div_cnt <= '0;
    else if (div_cnt == DIV_W'(CHAR_PERIOD - 1)) div_cnt <= '0;
    else                                        div_cnt <= div_cnt + DIV_W'(1);
  end

  assign tick = speed && (div_cnt == DIV_W'(CHAR_PERIOD - 1));

  always_comb begin
    iobus_iob_out = '0;
    if (sel && iobus_iob_fm_status) begin
      iobus_iob_out[ST_OVR]              = ovr;
      iobus_iob_out[ST_FULL]             = fifo_full;
      iobus_iob_out[ST_EMPTY]            = fifo_empty;
      iobus_iob_out[ST_B]                = b;
      iobus_iob_out[ST_BUSY]             = busy;
      iobus_iob_out[ST_FLAG]             = flag;
      iobus_iob_out[ST_PIA_HI:ST_PIA_LO] = pia;
    end
  end

  always_comb begin
    iobus_pi_req = '0;
    for (int i = 1; i <= 7; i++) iobus_pi_req[i] = flag && (pia == 3'(i));
  end

  always_comb begin
    s_readdata = '0;
    if (fe_data_rq && !fifo_empty) s_readdata[CHAR_W-1:0] = fifo_dout;
  end

  assign ptp_ind    = fifo_empty ? '0 : fifo_dout;
  assign status_ind = {ovr, fifo_full, speed, b, busy, flag, pia};
  assign unused_ok  = &{1'b0, iobus_iob_fm_datai, iobus_iob_in, fifo_count};

endmodule

// File: tb/tb_ptp_buf.sv
// Directed bench for ptp_buf: a table of bus operations with hand-computed
// register/status results, then multi-cycle sequences for FIFO, motor and reset.
module tb_ptp_buf;
  import ptp_pkg::*;

  localparam int DEPTH       = 4;
  localparam int CHAR_W      = 8;
  localparam int SPEED_DLY   = 20;
  localparam int CHAR_PERIOD = 8;
  localparam int IDLE_HOLD   = 40;

  localparam int OP_DCLR  = 0;
  localparam int OP_DSET  = 1;
  localparam int OP_CCLR  = 2;
  localparam int OP_CSET  = 3;
  localparam int OP_IORST = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              poweron, iob_reset, datao_clear, datao_set, cono_clear, cono_set;
  logic              fm_datai, fm_status;
  logic [3:9]        ios;
  logic [0:35]       iob_in;
  logic [1:7]        pi_req;
  logic [0:35]       iob_out;
  logic              key;
  logic [CHAR_W-1:0] ptp_ind;
  logic [8:0]        status_ind;
  logic              s_read;
  logic [31:0]       s_readdata;
  logic              rq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          op;
    logic [35:0] data;
    logic [8:0]  st_ind;
    logic [6:0]  pi;
    logic [8:0]  st_word;
  } vec_t;

  vec_t tab [7];

  ptp_buf #(
    .DEPTH       (DEPTH),
    .CHAR_W      (CHAR_W),
    .SPEED_DLY   (SPEED_DLY),
    .CHAR_PERIOD (CHAR_PERIOD),
    .IDLE_HOLD   (IDLE_HOLD)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .iobus_iob_poweron   (poweron),
    .iobus_iob_reset     (iob_reset),
    .iobus_datao_clear   (datao_clear),
    .iobus_datao_set     (datao_set),
    .iobus_cono_clear    (cono_clear),
    .iobus_cono_set      (cono_set),
    .iobus_iob_fm_datai  (fm_datai),
    .iobus_iob_fm_status (fm_status),
    .iobus_ios           (ios),
    .iobus_iob_in        (iob_in),
    .iobus_pi_req        (pi_req),
    .iobus_iob_out       (iob_out),
    .key_tape_feed       (key),
    .ptp_ind             (ptp_ind),
    .status_ind          (status_ind),
    .s_read              (s_read),
    .s_readdata          (s_readdata),
    .fe_data_rq          (rq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic set_lvl(input int op, input logic v);
    case (op)
      OP_DCLR: datao_clear = v;
      OP_DSET: datao_set   = v;
      OP_CCLR: cono_clear  = v;
      OP_CSET: cono_set    = v;
      default: iob_reset   = v;
    endcase
  endtask

  // Level high for 'hold' cycles; returns at the negedge after the acting edge(s)
  task automatic bus_pulse(input int op, input logic [35:0] data, input int hold);
    @(negedge clk);
    iob_in = data;
    set_lvl(op, 1'b1);
    repeat (hold) @(negedge clk);
    set_lvl(op, 1'b0);
  endtask

  task automatic wait_rq(input string name, output int at);
    int n;
    n  = 0;
    at = -1;
    while (rq !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rq !== 1'b1) begin
      errors++;
      $display("FAIL %s: fe_data_rq timeout got 0 expected 1", name);
    end else begin
      at = cyc;
    end
  endtask

  task automatic read_chr(input string name, input logic [31:0] exp);
    int at;
    wait_rq(name, at);
    chk(name, s_readdata, exp);
    s_read = 1'b1;
    @(negedge clk);
    s_read = 1'b0;
    chk({name, "_rq_clear"}, rq, 1'b0);
  endtask

  initial begin
    int n, at, prev;

    tab[0] = '{OP_CSET,  36'o15, 9'o015, 7'b0000100, 9'o115};
    tab[1] = '{OP_DCLR,  36'o0,  9'o005, 7'b0000000, 9'o105};
    tab[2] = '{OP_CSET,  36'o13, 9'o013, 7'b0010000, 9'o113};
    tab[3] = '{OP_CSET,  36'o47, 9'o057, 7'b0000001, 9'o157};
    tab[4] = '{OP_CCLR,  36'o0,  9'o000, 7'b0000000, 9'o100};
    tab[5] = '{OP_CSET,  36'o10, 9'o010, 7'b0000000, 9'o110};
    tab[6] = '{OP_IORST, 36'o0,  9'o000, 7'b0000000, 9'o100};

    reset = 1'b1; poweron = 1'b1; iob_reset = 1'b0;
    datao_clear = 1'b0; datao_set = 1'b0; cono_clear = 1'b0; cono_set = 1'b0;
    fm_datai = 1'b0; fm_status = 1'b0; ios = '0; iob_in = '0;
    key = 1'b0; s_read = 1'b0;

    #12;
    chk("rst_pi_req", pi_req, 0);
    chk("rst_iob_out", iob_out, 0);
    chk("rst_readdata", s_readdata, 0);
    chk("rst_rq", rq, 0);
    chk("rst_ptp_ind", ptp_ind, 0);
    chk("rst_status_ind", status_ind, 0);
    chk("rst_motor_off", dut.mot_state == MOT_OFF, 1);

    @(negedge clk);
    reset = 1'b0;
    ios = DEVCODE_DEF;
    fm_status = 1'b1;
    @(negedge clk);
    chk("idle_status_word", iob_out, 36'o100);

    for (int i = 0; i < 7; i++) begin
      bus_pulse(tab[i].op, tab[i].data, 1);
      chk($sformatf("tab%0d_status_ind", i), status_ind, tab[i].st_ind);
      chk($sformatf("tab%0d_pi_req", i), pi_req, tab[i].pi);
      chk($sformatf("tab%0d_iob_out", i), iob_out, {27'b0, tab[i].st_word});
    end

    ios = 7'b001_000_1;
    #1 chk("desel_iob_out", iob_out, 0);
    bus_pulse(OP_DSET, 36'o55, 1);
    chk("desel_datao_ignored", dut.u_fifo.count, 0);
    ios = DEVCODE_DEF;
    fm_status = 1'b0;
    #1 chk("no_fm_status_iob_out", iob_out, 0);
    fm_status = 1'b1;

    // Fill past capacity while the motor is still spinning up
    for (int i = 0; i < 5; i++) bus_pulse(OP_DSET, 36'o101 + 36'(i), 1);
    chk("fill_count", dut.u_fifo.count, 4);
    chk("fill_status_ind", status_ind, 9'o620);
    chk("fill_status_word", iob_out, 36'o620);
    chk("fill_head", ptp_ind, 8'o101);
    bus_pulse(OP_CSET, 36'o100, 1);
    chk("ovr_cleared", status_ind, 9'o220);

    for (int k = 0; k < 4; k++) begin
      read_chr($sformatf("drain%0d", k), 32'o101 + 32'(k));
      chk($sformatf("drain%0d_flag", k), status_ind[3], 1'b1);
      bus_pulse(OP_DCLR, 36'o0, 1);
    end
    repeat (3) @(negedge clk);
    chk("drain_busy_clear", status_ind[4], 1'b0);
    chk("drain_empty", dut.u_fifo.count, 0);

    bus_pulse(OP_CSET, 36'o40, 1);
    bus_pulse(OP_DSET, 36'o077, 3);
    chk("held_datao_once", dut.u_fifo.count, 1);
    chk("binary_head", ptp_ind, 8'o277);
    read_chr("binary_punch", 32'o277);
    bus_pulse(OP_CCLR, 36'o0, 1);

    bus_pulse(OP_DSET, 36'o061, 1);
    bus_pulse(OP_DSET, 36'o062, 1);
    chk("simul_pre_count", dut.u_fifo.count, 2);
    wait_rq("simul_rq", at);
    chk("simul_first", s_readdata, 32'o061);
    iob_in = 36'o063;
    datao_set = 1'b1;
    s_read = 1'b1;
    @(negedge clk);
    datao_set = 1'b0;
    s_read = 1'b0;
    chk("simul_count", dut.u_fifo.count, 2);
    chk("simul_head", ptp_ind, 8'o062);
    read_chr("simul_second", 32'o062);
    read_chr("simul_third", 32'o063);

    n = 0;
    while (dut.mot_state != MOT_OFF && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("motor_off_before_feed", dut.mot_state == MOT_OFF, 1);
    key = 1'b1;
    n = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (status_ind[6]) break;
      n++;
    end
    chk("feed_spinup_cycles", n, SPEED_DLY);
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      wait_rq($sformatf("feed%0d_rq", k), at);
      chk($sformatf("feed%0d_zero", k), s_readdata, 0);
      if (k > 0) chk($sformatf("feed%0d_period", k), at - prev, CHAR_PERIOD);
      prev = at;
      s_read = 1'b1;
      @(negedge clk);
      s_read = 1'b0;
    end
    key = 1'b0;
    n = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (dut.mot_state == MOT_HOLD) n++;
      else break;
    end
    chk("hold_cycles", n, IDLE_HOLD);
    chk("motor_off_after_hold", dut.mot_state == MOT_OFF, 1);

    bus_pulse(OP_DSET, 36'o121, 1);
    bus_pulse(OP_DSET, 36'o122, 1);
    wait_rq("iorst_rq", at);
    bus_pulse(OP_IORST, 36'o0, 1);
    chk("iorst_rq_clear", rq, 0);
    chk("iorst_flush", dut.u_fifo.count, 0);
    chk("iorst_ptp_ind", ptp_ind, 0);

    bus_pulse(OP_DSET, 36'o111, 1);
    wait_rq("areset_rq", at);
    chk("areset_pre_data", s_readdata, 32'o111);
    #2 reset = 1'b1;
    #1;
    chk("areset_rq", rq, 0);
    chk("areset_readdata", s_readdata, 0);
    chk("areset_ptp_ind", ptp_ind, 0);
    chk("areset_status_ind", status_ind, 0);
    chk("areset_pi_req", pi_req, 0);
    chk("areset_count", dut.u_fifo.count, 0);
    chk("areset_motor", dut.mot_state == MOT_OFF, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_rq", rq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
